// File: rtl/mul_booth_iter_if.sv
// ============================================================================
//  Module      : mul_booth_iter_if
//  Description : Operand / product handshake bundle for mul_booth_iter.
//                Operand side: in_valid / in_ready carrying a, b (and signed_i
//                when MUL_BOOTH_SIGNED_EN is defined).
//                Product side: out_valid / out_ready carrying c.
//                The master modport is the operand producer / product consumer.
//                The slave modport is the multiplier.
//  Config      : MUL_BOOTH_SIGNED_EN adds the signed_i operand qualifier.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mul_booth_iter_if #(
    parameter int BITLEN = 17
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BITLEN-1:0]     a;
    logic [BITLEN-1:0]     b;
`ifdef MUL_BOOTH_SIGNED_EN
    logic                  signed_i;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [2*BITLEN-1:0]   c;

`ifdef MUL_BOOTH_SIGNED_EN
    modport master (
        output in_valid, a, b, signed_i, out_ready,
        input  in_ready, out_valid, c
    );

    modport slave (
        input  in_valid, a, b, signed_i, out_ready,
        output in_ready, out_valid, c
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c
    );
`endif

endinterface : mul_booth_iter_if

`default_nettype wire

// File: rtl/mul_booth_iter.sv
// ============================================================================
//  Module      : mul_booth_iter
//  Description : Iterative radix-4 Booth multiplier. Operands are latched on
//                acceptance. DIGITS_PER_CYCLE Booth rows are then retired into
//                a 2*BITLEN carry-propagate accumulator each BUSY cycle. The
//                product is presented in DONE until it is taken. Only one
//                operation is in flight at a time. A new operand pair may be
//                accepted in the same cycle the previous product is taken.
//  Config      : MUL_BOOTH_SIGNED_EN adds signed_i (two's complement operands).
//                Without it, all operands are treated as unsigned.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_booth_iter #(
    parameter int BITLEN           = 17,
    parameter int DIGITS_PER_CYCLE = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mul_booth_iter_if.slave    bus
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int NDIG = BITLEN / 2 + 1;                                  // Booth digits
    localparam int NCYC = (NDIG + DIGITS_PER_CYCLE - 1) / DIGITS_PER_CYCLE; // BUSY cycles
    localparam int PW   = 2 * BITLEN;                                      // product width
    localparam int BEXT = 2 * NDIG + 1;                                    // b_ext width
    localparam int BXW  = BEXT + 1;                                        // b_ext plus b_ext[-1]
    localparam int KW   = $clog2(NCYC * DIGITS_PER_CYCLE + 1);             // digit index width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [BITLEN-1:0]  r_a;
    // r_bx[0] holds b_ext[-1] (always 0). r_bx[i+1] holds b_ext[i].
    logic [BXW-1:0]     r_bx;
    logic               r_sgn;
    logic [KW-1:0]      r_k;
    logic [PW-1:0]      r_acc;

    logic               w_accept;
    logic               w_last;
    logic               w_sgn_in;
    logic [BEXT-1:0]    w_b_ext;
    logic [PW-1:0]      w_aext;
    logic [PW-1:0]      w_sum;

`ifdef MUL_BOOTH_SIGNED_EN
    assign w_sgn_in = bus.signed_i;
`else
    assign w_sgn_in = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    assign bus.in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.c         = r_acc;

    assign w_accept = bus.in_valid && bus.in_ready;

    // This is the last BUSY cycle once the current group reaches the top digit.
    assign w_last = (int'(r_k) + DIGITS_PER_CYCLE) >= NDIG;

    // Multiplier recoding source: b extended to 2*NDIG+1 bits.
    assign w_b_ext = {{(BEXT - BITLEN){w_sgn_in & bus.b[BITLEN-1]}}, bus.b};

    // Multiplicand extended to the full product width.
    assign w_aext = {{BITLEN{r_sgn & r_a[BITLEN-1]}}, r_a};

    // ------------------------------------------------------------------------
    // Booth row generation and accumulation for the current digit group
    // ------------------------------------------------------------------------
    // Sum DIGITS_PER_CYCLE Booth rows starting at digit r_k into the accumulator.
    always_comb begin : p_rows
        int           idx;
        logic [2:0]   trip;
        logic         neg;
        logic         two;
        logic         zero;
        logic [PW-1:0] mag;
        logic [PW-1:0] row;

        w_sum = r_acc;
        idx   = 0;
        trip  = 3'b000;
        neg   = 1'b0;
        two   = 1'b0;
        zero  = 1'b1;
        mag   = '0;
        row   = '0;

        for (int d = 0; d < DIGITS_PER_CYCLE; d++) begin
            idx  = int'(r_k) + d;
            trip = 3'(r_bx >> (2 * idx));
            neg  = 1'b0;
            two  = 1'b0;
            zero = 1'b0;

            case (trip)
                3'b001, 3'b010: begin neg = 1'b0; two = 1'b0; end   // +A
                3'b011:         begin neg = 1'b0; two = 1'b1; end   // +2A
                3'b100:         begin neg = 1'b1; two = 1'b1; end   // -2A
                3'b101, 3'b110: begin neg = 1'b1; two = 1'b0; end   // -A
                default:        zero = 1'b1;                        // 000 / 111 -> 0
            endcase

            mag = two ? (w_aext << 1) : w_aext;
            // Negative rows use one's complement here. The +1 is added at the row LSB below.
            row = neg ? ~mag : mag;

            // Digits past the top of the recoding contribute nothing.
            if (idx < NDIG && !zero) begin
                w_sum = w_sum + (row << (2 * idx)) + (PW'(neg) << (2 * idx));
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register. Reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE/DONE accept into BUSY, BUSY runs NCYC cycles, DONE waits on out_ready.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = ST_BUSY;
                end else if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // Latch operands and clear the accumulator on accept. Retire one digit group per BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_bx  <= '0;
            r_sgn <= 1'b0;
            r_k   <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_a   <= bus.a;
            r_bx  <= {w_b_ext, 1'b0};
            r_sgn <= w_sgn_in;
            r_k   <= '0;
            r_acc <= '0;
        end else if (r_state == ST_BUSY) begin
            r_acc <= w_sum;
            r_k   <= r_k + KW'(DIGITS_PER_CYCLE);
        end
    end

endmodule : mul_booth_iter

`default_nettype wire

// File: tb/tb_mul_booth_iter.sv
// ============================================================================
//  Module      : tb_mul_booth_iter
//  Description : Directed, self-checking bench for mul_booth_iter. It covers a
//                17-bit / 3-digit instance and an 8-bit / 1-digit instance.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul_booth_iter;

`ifdef MUL_BOOTH_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    localparam int LAT17 = 4;   // NDIG=9, DPC=3 -> NCYC=3, out_valid NCYC+1 cycles after accept
    localparam int LAT8  = 6;   // NDIG=5, DPC=1 -> NCYC=5

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    mul_booth_iter_if #(.BITLEN(17)) bus17 ();
    mul_booth_iter_if #(.BITLEN(8))  bus8  ();

    mul_booth_iter u_dut17 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus17)
    );

    mul_booth_iter #(.BITLEN(8), .DIGITS_PER_CYCLE(1)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [16:0] a;
        logic [16:0] b;
        logic        sgn;
        logic [33:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Issue one 17-bit op with out_ready=1. Check latency and product.
    task automatic run17(input string name, input logic [16:0] a, input logic [16:0] b,
                         input logic [33:0] exp);
        int n;
        @(negedge clk);
        bus17.a         = a;
        bus17.b         = b;
        bus17.in_valid  = 1'b1;
        bus17.out_ready = 1'b1;
        n = 0;
        while (!bus17.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bus17.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus17.out_valid && n < 40);
        chk({name, " latency"}, 64'(n), 64'(LAT17));
        chk({name, " product"}, 64'(bus17.c), 64'(exp));
    endtask

    task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit check_lat);
        int n;
        @(negedge clk);
        bus8.a         = a;
        bus8.b         = b;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b1;
        n = 0;
        while (!bus8.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus8.out_valid && n < 40);
        if (check_lat || n != LAT8) chk({name, " latency"}, 64'(n), 64'(LAT8));
        chk({name, " product"}, 64'(bus8.c), 64'(exp));
    endtask

    initial begin : main
        int  n;
        bit  ok;
        logic [7:0] ra, rb;

        checks = 0;
        errors = 0;

        vecs[0]  = '{"max_sq",    17'h1FFFF, 17'h1FFFF, 1'b0, 34'h3FFFC0001};
        vecs[1]  = '{"zero_b",    17'h12345, 17'h00000, 1'b0, 34'h0};
        vecs[2]  = '{"one_a",     17'h00001, 17'h1ABCD, 1'b0, 34'h1ABCD};
        vecs[3]  = '{"three5",    17'h00003, 17'h00005, 1'b0, 34'hF};
        vecs[4]  = '{"msb_sq",    17'h10000, 17'h10000, 1'b0, 34'h100000000};
        vecs[5]  = '{"max_x3",    17'h1FFFF, 17'h00003, 1'b0, 34'h5FFFD};
        vecs[6]  = '{"shift4",    17'h0ABCD, 17'h00010, 1'b0, 34'hABCD0};
        vecs[7]  = '{"alt_x2",    17'h15555, 17'h00002, 1'b0, 34'h2AAAA};
        vecs[8]  = '{"max_x1",    17'h1FFFF, 17'h00001, 1'b0, 34'h1FFFF};
        vecs[9]  = '{"max_msb",   17'h1FFFF, 17'h10000, 1'b0, 34'h1FFFF0000};
        vecs[10] = '{"s_msb_sq",  17'h10000, 17'h10000, 1'b1, 34'h100000000};
        vecs[11] = '{"s_m1_x3",   17'h1FFFF, 17'h00003, 1'b1, 34'h3FFFFFFFD};
        vecs[12] = '{"s_m1_m1",   17'h1FFFF, 17'h1FFFF, 1'b1, 34'h1};
        vecs[13] = '{"s_5_m3",    17'h00005, 17'h1FFFD, 1'b1, 34'h3FFFFFFF1};

        bus17.in_valid  = 1'b0;
        bus17.out_ready = 1'b0;
        bus17.a         = '0;
        bus17.b         = '0;
`ifdef MUL_BOOTH_SIGNED_EN
        bus17.signed_i  = 1'b0;
`endif
        bus8.in_valid   = 1'b0;
        bus8.out_ready  = 1'b0;
        bus8.a          = '0;
        bus8.b          = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst in_ready",  64'(bus17.in_ready),  64'd1);
        chk("rst out_valid", 64'(bus17.out_valid), 64'd0);
        chk("rst c",         64'(bus17.c),         64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].sgn && !SIGNED_BUILD) continue;
`ifdef MUL_BOOTH_SIGNED_EN
            bus17.signed_i = vecs[i].sgn;
`endif
            run17(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp);
        end
`ifdef MUL_BOOTH_SIGNED_EN
        bus17.signed_i = 1'b0;
`endif

        // Back-to-back: operands change after accept. The second op is accepted in the DONE cycle.
        @(negedge clk);
        bus17.a = 17'h12345; bus17.b = 17'h00000;
        bus17.in_valid = 1'b1; bus17.out_ready = 1'b1;
        @(posedge clk);
        #1 bus17.a = 17'h00001; bus17.b = 17'h1ABCD;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus17.out_valid && n < 40);
        chk("b2b first latency",  64'(n),               64'(LAT17));
        chk("b2b first product",  64'(bus17.c),         64'h0);
        chk("b2b in_ready@done",  64'(bus17.in_ready),  64'd1);
        @(posedge clk);
        #1 bus17.in_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus17.out_valid && n < 40);
        chk("b2b second latency", 64'(n),               64'(LAT17));
        chk("b2b second product", 64'(bus17.c),         64'h1ABCD);

        // Backpressure: hold out_ready low for 5 cycles in DONE.
        @(negedge clk);
        bus17.a = 17'd7; bus17.b = 17'd9;
        bus17.in_valid = 1'b1; bus17.out_ready = 1'b0;
        @(posedge clk);
        #1 bus17.a = 17'h1FFFF; bus17.b = 17'h1FFFF;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus17.out_valid && n < 40);
        chk("bp latency", 64'(n), 64'(LAT17));
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus17.c !== 34'd63 || bus17.out_valid !== 1'b1 || bus17.in_ready !== 1'b0) ok = 1'b0;
        end
        chk("bp hold stable", 64'(ok), 64'd1);
        bus17.out_ready = 1'b1;
        bus17.in_valid  = 1'b0;
        @(negedge clk);
        chk("bp single transfer", 64'(bus17.out_valid), 64'd0);
        chk("bp idle in_ready",   64'(bus17.in_ready),  64'd1);

        // Reset dropped in the second BUSY cycle.
        @(negedge clk);
        bus17.a = 17'h1FFFF; bus17.b = 17'h1FFFF;
        bus17.in_valid = 1'b1; bus17.out_ready = 1'b1;
        @(posedge clk);
        #1 bus17.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 64'(bus17.out_valid), 64'd0);
        chk("midrst c",         64'(bus17.c),         64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus17.out_valid !== 1'b0 || bus17.in_ready !== 1'b1) ok = 1'b0;
        end
        chk("midrst no pulse", 64'(ok), 64'd1);
        run17("midrst next 3x5", 17'd3, 17'd5, 34'd15);

        // 8-bit / one digit per cycle instance.
        run8("b8 ff_sq", 8'hFF, 8'hFF, 16'hFE01, 1'b1);
        run8("b8 zero",  8'h00, 8'hA5, 16'h0000, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run8("b8 rand", ra, rb, 16'({8'h00, ra} * {8'h00, rb}), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mul_booth_iter

`default_nettype wire
